// File: rtl/fixed_sample_capture_if.sv
// ============================================================================
// Module      : fixed_sample_capture_if
// Description : Valid/ready drain port carrying signed fixed-point samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fixed_sample_capture_if #(
   parameter int WIDTH = 25
);
   logic signed [WIDTH-1:0] out_data;
   logic                    out_valid;
   logic                    out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

`default_nettype wire

// File: rtl/fixed_sample_capture.sv
// ============================================================================
// Module      : fixed_sample_capture
// Description : Decimating capture of a signed fixed-point model output into
//               a FIFO drained over valid/ready, with drop/range statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_sample_capture #(
   parameter int WIDTH    = 25,
   parameter int EXPONENT = -16,
   parameter int DECIM    = 1,
   parameter int DEPTH    = 16,
   parameter int LIMIT    = 2**23
) (
   input  wire logic                      clk,
   input  wire logic                      rst,
   input  wire logic                      en,
   input  wire logic signed [WIDTH-1:0]   in_,
   fixed_sample_capture_if.master         out_if,
   output logic signed [31:0]             exponent_o,
   output logic [$clog2(DEPTH):0]         level,
   output logic [15:0]                    drop_count,
   output logic                           range_err,
   input  wire logic                      clear_stats
);
   localparam int              AW        = $clog2(DEPTH);
   localparam logic [15:0]     c_cnt_max = 16'(DECIM - 1);
   localparam logic [WIDTH:0]  c_limit   = (WIDTH+1)'(LIMIT);

   logic [15:0]               cnt_q, cnt_d;
   logic [AW:0]               wr_ptr_q, wr_ptr_d;
   logic [AW:0]               rd_ptr_q, rd_ptr_d;
   logic signed [WIDTH-1:0]   mem_q [DEPTH];
   logic signed [WIDTH-1:0]   mem_d [DEPTH];
   logic [15:0]               drop_count_q, drop_count_d;
   logic                      range_err_q, range_err_d;

   logic                      strobe;
   logic                      empty;
   logic                      full;
   logic                      pop;
   logic                      push;
   logic                      drop;
   logic [WIDTH:0]            in_ext;
   logic [WIDTH:0]            magnitude;
   logic                      violation;

   always_comb begin
      strobe = en && (cnt_q == c_cnt_max);
      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop    = !empty && out_if.out_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push   = strobe && (!full || pop);
      drop   = strobe && full && !pop;

      // One extra bit so negating the most negative sample cannot wrap.
      in_ext    = {in_[WIDTH-1], in_};
      magnitude = in_[WIDTH-1] ? (~in_ext + 1'b1) : in_ext;
      violation = strobe && (magnitude > c_limit);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = (cnt_q == c_cnt_max) ? 16'd0 : cnt_q + 16'd1;
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = in_;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      drop_count_d = drop_count_q;
      if (drop) begin
         if (clear_stats) begin
            drop_count_d = 16'd1;
         end else if (drop_count_q != 16'hFFFF) begin
            drop_count_d = drop_count_q + 16'd1;
         end
      end else if (clear_stats) begin
         drop_count_d = 16'd0;
      end

      range_err_d = range_err_q;
      if (violation) begin
         range_err_d = 1'b1;
      end else if (clear_stats) begin
         range_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= 16'd0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         drop_count_q <= 16'd0;
         range_err_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q        <= cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         drop_count_q <= drop_count_d;
         range_err_q  <= range_err_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign out_if.out_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign out_if.out_valid = !empty;
   assign exponent_o       = 32'(EXPONENT);
   assign level            = wr_ptr_q - rd_ptr_q;
   assign drop_count       = drop_count_q;
   assign range_err        = range_err_q;
endmodule

`default_nettype wire

// File: tb/tb_fixed_sample_capture.sv
// ============================================================================
// Module      : tb_fixed_sample_capture
// Description : Directed bench for fixed_sample_capture (DECIM=1 and DECIM=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_sample_capture;
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en_a = 1'b0;
   logic               en_b = 1'b0;
   logic signed [24:0] in_ = '0;
   logic               clear_stats = 1'b0;

   logic signed [31:0] exp_a, exp_b;
   logic [4:0]         level_a, level_b;
   logic [15:0]        drop_a, drop_b;
   logic               rerr_a, rerr_b;

   int errors = 0;
   int checks = 0;

   fixed_sample_capture_if #(.WIDTH(25)) if_a ();
   fixed_sample_capture_if #(.WIDTH(25)) if_b ();

   fixed_sample_capture #(.WIDTH(25), .EXPONENT(-16), .DECIM(1), .DEPTH(16), .LIMIT(2**23)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .in_(in_), .out_if(if_a.master),
      .exponent_o(exp_a), .level(level_a), .drop_count(drop_a), .range_err(rerr_a),
      .clear_stats(clear_stats));

   fixed_sample_capture #(.WIDTH(25), .EXPONENT(-16), .DECIM(4), .DEPTH(16), .LIMIT(2**23)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .in_(in_), .out_if(if_b.master),
      .exponent_o(exp_b), .level(level_b), .drop_count(drop_b), .range_err(rerr_b),
      .clear_stats(clear_stats));

   always #5 clk = ~clk;

   // Advance one clock; observation and new stimulus happen 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en_a = 1'b0; en_b = 1'b0; clear_stats = 1'b0;
      if_a.out_ready = 1'b0; if_b.out_ready = 1'b0; in_ = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", if_a.out_valid); end
      checks++; if (if_a.out_data !== 25'sd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", if_a.out_data); end
      checks++; if (level_a !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_a); end
      checks++; if (drop_a !== 16'd0 || rerr_a !== 1'b0) begin errors++; $display("FAIL reset_stats got=%0d/%0b exp=0/0", drop_a, rerr_a); end
      checks++; if (exp_a !== -32'sd16) begin errors++; $display("FAIL exponent got=%0d exp=-16", exp_a); end
   endtask

   task automatic test_stream();
      do_reset();
      if_a.out_ready = 1'b1; en_a = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         in_ = 25'(k);
         step();
         checks++;
         if (if_a.out_valid !== 1'b1 || if_a.out_data !== 25'(k) || level_a !== 5'd1) begin
            errors++;
            $display("FAIL stream_%0d got v=%0b d=%0d lvl=%0d exp v=1 d=%0d lvl=1", k, if_a.out_valid, if_a.out_data, level_a, k);
         end
      end
      en_a = 1'b0;
      step();
      checks++; if (if_a.out_valid !== 1'b0 || level_a !== 5'd0) begin errors++; $display("FAIL stream_empty got v=%0b lvl=%0d exp 0/0", if_a.out_valid, level_a); end
   endtask

   task automatic test_decim();
      logic [4:0] pat;
      do_reset();
      pat = 5'b11101; // bit i is en for step i
      for (int i = 0; i < 5; i++) begin
         en_b = pat[i];
         in_  = 25'(50 + i);
         step();
         checks++;
         if (if_b.out_valid !== (i == 4)) begin
            errors++; $display("FAIL decim_step%0d got valid=%0b exp=%0b", i, if_b.out_valid, (i == 4));
         end
      end
      checks++; if (if_b.out_data !== 25'sd54 || level_b !== 5'd1) begin errors++; $display("FAIL decim_data got d=%0d lvl=%0d exp d=54 lvl=1", if_b.out_data, level_b); end
      en_b = 1'b0;
      step();
      checks++; if (level_b !== 5'd1) begin errors++; $display("FAIL decim_hold got lvl=%0d exp=1", level_b); end
   endtask

   task automatic test_full_drain();
      do_reset();
      en_a = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         in_ = 25'(k);
         step();
      end
      en_a = 1'b0;
      checks++; if (level_a !== 5'd16) begin errors++; $display("FAIL full_level got=%0d exp=16", level_a); end
      checks++; if (drop_a !== 16'd4) begin errors++; $display("FAIL full_drops got=%0d exp=4", drop_a); end
      step();
      checks++; if (if_a.out_data !== 25'sd1 || if_a.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got d=%0d v=%0b exp d=1 v=1", if_a.out_data, if_a.out_valid); end
      if_a.out_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         checks++;
         if (if_a.out_data !== 25'(k) || if_a.out_valid !== 1'b1) begin
            errors++; $display("FAIL drain_%0d got d=%0d v=%0b exp d=%0d v=1", k, if_a.out_data, if_a.out_valid, k);
         end
         step();
      end
      checks++; if (if_a.out_valid !== 1'b0 || level_a !== 5'd0) begin errors++; $display("FAIL drain_empty got v=%0b lvl=%0d exp 0/0", if_a.out_valid, level_a); end
      if_a.out_ready = 1'b0;
   endtask

   task automatic test_push_pop_full();
      do_reset();
      en_a = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         in_ = 25'(k);
         step();
      end
      in_ = 25'sd100; if_a.out_ready = 1'b1;
      step();
      en_a = 1'b0; if_a.out_ready = 1'b0;
      checks++; if (level_a !== 5'd16) begin errors++; $display("FAIL pushpop_level got=%0d exp=16", level_a); end
      checks++; if (drop_a !== 16'd0) begin errors++; $display("FAIL pushpop_drops got=%0d exp=0", drop_a); end
      checks++; if (if_a.out_data !== 25'sd2) begin errors++; $display("FAIL pushpop_head got=%0d exp=2", if_a.out_data); end
   endtask

   task automatic test_range();
      do_reset();
      en_a = 1'b1;
      in_ = 25'sd8388608;   // +LIMIT exactly: allowed
      step();
      in_ = -25'sd8388608;  // -LIMIT exactly: allowed
      step();
      en_a = 1'b0;
      checks++; if (rerr_a !== 1'b0) begin errors++; $display("FAIL range_at_limit got=%0b exp=0", rerr_a); end
      en_a = 1'b1;
      in_ = 25'h1000000;    // most negative value, |v| = 2^24
      step();
      en_a = 1'b0;
      checks++; if (rerr_a !== 1'b1) begin errors++; $display("FAIL range_set got=%0b exp=1", rerr_a); end
      checks++; if (level_a !== 5'd3) begin errors++; $display("FAIL range_stored got lvl=%0d exp=3", level_a); end
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      checks++; if (rerr_a !== 1'b0 || level_a !== 5'd3) begin errors++; $display("FAIL range_clear got err=%0b lvl=%0d exp 0/3", rerr_a, level_a); end
      clear_stats = 1'b1; en_a = 1'b1; in_ = 25'sd9000000;
      step();
      clear_stats = 1'b0; en_a = 1'b0;
      checks++; if (rerr_a !== 1'b1) begin errors++; $display("FAIL range_clear_wins got=%0b exp=1", rerr_a); end
      if_a.out_ready = 1'b1;
      step(); step();
      checks++; if (if_a.out_data !== 25'h1000000) begin errors++; $display("FAIL range_value got=%0d exp=%0d", if_a.out_data, 25'sh1000000); end
      if_a.out_ready = 1'b0;
   endtask

   task automatic test_mid_drain_reset();
      do_reset();
      en_a = 1'b1; en_b = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         in_ = (k == 5) ? 25'h1000000 : 25'(k);
         step();
      end
      en_a = 1'b0;
      checks++; if (level_a !== 5'd5 || rerr_a !== 1'b1) begin errors++; $display("FAIL prerst got lvl=%0d err=%0b exp 5/1", level_a, rerr_a); end
      checks++; if (level_b !== 5'd1) begin errors++; $display("FAIL prerst_b got lvl=%0d exp=1", level_b); end
      if_a.out_ready = 1'b1;
      step();               // one pop; counter of dut_b now at 2
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (if_a.out_valid !== 1'b0 || level_a !== 5'd0) begin errors++; $display("FAIL rst_fifo got v=%0b lvl=%0d exp 0/0", if_a.out_valid, level_a); end
      checks++; if (rerr_a !== 1'b0 || drop_a !== 16'd0) begin errors++; $display("FAIL rst_stats got err=%0b drop=%0d exp 0/0", rerr_a, drop_a); end
      checks++; if (if_b.out_valid !== 1'b0) begin errors++; $display("FAIL rst_fifo_b got v=%0b exp=0", if_b.out_valid); end
      // Counter restarts from 0: three enabled cycles capture nothing, the fourth captures.
      en_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_ = 25'(70 + i);
         step();
         checks++;
         if (if_b.out_valid !== (i == 3)) begin
            errors++; $display("FAIL rst_cnt_step%0d got valid=%0b exp=%0b", i, if_b.out_valid, (i == 3));
         end
      end
      en_b = 1'b0; if_a.out_ready = 1'b0;
      checks++; if (if_b.out_data !== 25'sd73) begin errors++; $display("FAIL rst_cnt_data got=%0d exp=73", if_b.out_data); end
   endtask

   initial begin
      if_a.out_ready = 1'b0;
      if_b.out_ready = 1'b0;
      test_reset();
      test_stream();
      test_decim();
      test_full_drain();
      test_push_pop_full();
      test_range();
      test_mid_drain_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
